shift_seq_ctrl: RTL and testbench

Sequential controller for arithmetic left shifts in the arithmetic unit. It accepts one operand pair (A, B) per transaction over a valid/ready handshake and shifts A left by one position per clock, B times. It flags error and overflow, then holds the registered result until the consumer accepts it. It is the clocked, multi-cycle counterpart of the combinational shift unit and uses the same A/B/result/error/overflow semantics at its ports.

---
 rtl/shift_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Sequential arithmetic left shifter: accepts (A, B) over valid/ready and
// shifts A left one bit per clock, B times (clamped to BITS), tracking
// sign-change overflow. The result is held in DONE until the consumer takes it.
module shift_seq_ctrl #(
   parameter int BITS = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   output logic            o_in_ready,
   input  logic [BITS-1:0] i_arg_A,
   input  logic [BITS-1:0] i_arg_B,
   input  logic            i_clear,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [BITS-1:0] o_result,
   output logic            o_error,
   output logic            o_overflow,
   output logic            o_busy
);

   localparam int CW = $clog2(BITS + 1);
   localparam logic [BITS-1:0] BITS_V  = BITS'(BITS);
   localparam logic [CW-1:0]   CNT_MAX = CW'(BITS);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state_q, state_d;
   logic [BITS-1:0] acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            ovf_q, ovf_d;
   logic            valid_q, valid_d;
   logic [BITS-1:0] result_q, result_d;
   logic            error_q, error_d;
   logic            overflow_q, overflow_d;

   // Next-state datapath; output registers are loaded from next-state values
   // so o_valid/o_result appear in the same cycle the FSM sits in DONE.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               acc_d = i_arg_A;
               err_d = i_arg_B[BITS-1];
               ovf_d = 1'b0;
               if (i_arg_B[BITS-1])
                  cnt_d = '0;
               else if (i_arg_B >= BITS_V)
                  cnt_d = CNT_MAX;
               else
                  cnt_d = i_arg_B[CW-1:0];
               state_d = (i_arg_B[BITS-1] || i_arg_B == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            // Any top-two-bit disagreement before a shift means a sign change.
            ovf_d = ovf_q | (acc_q[BITS-1] ^ acc_q[BITS-2]);
            acc_d = {acc_q[BITS-2:0], 1'b0};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1))
               state_d = DONE;
         end
         DONE: begin
            if (i_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Abort wins over everything, including an accept in IDLE.
      if (i_clear) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         err_d   = 1'b0;
         ovf_d   = 1'b0;
      end
      valid_d    = (state_d == DONE);
      result_d   = (valid_d && !err_d) ? acc_d : '0;
      error_d    = valid_d && err_d;
      overflow_d = valid_d && !err_d && ovf_d;
   end

   // State, datapath and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
         result_q   <= '0;
         error_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
         result_q   <= result_d;
         error_q    <= error_d;
         overflow_q <= overflow_d;
      end
   end

   assign o_valid    = valid_q;
   assign o_result   = result_q;
   assign o_error    = error_q;
   assign o_overflow = overflow_q;
   assign o_in_ready = (state_q == IDLE);
   assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: table of directed vectors plus random vectors
// checked through a scoreboard queue, then clear / reset corner sequences.
module tb_shift_seq_ctrl;

   localparam int BITS = 32;

   logic            i_clk = 1'b0;
   logic            i_rst_n = 1'b0;
   logic            i_valid = 1'b0;
   logic            i_clear = 1'b0;
   logic            i_ready = 1'b1;
   logic [BITS-1:0] i_arg_A = '0;
   logic [BITS-1:0] i_arg_B = '0;
   logic            o_in_ready, o_valid, o_error, o_overflow, o_busy;
   logic [BITS-1:0] o_result;

   shift_seq_ctrl #(.BITS(BITS)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_in_ready(o_in_ready),
      .i_arg_A(i_arg_A), .i_arg_B(i_arg_B), .i_clear(i_clear), .o_valid(o_valid),
      .i_ready(i_ready), .o_result(o_result), .o_error(o_error),
      .o_overflow(o_overflow), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      int          hold;
      logic [31:0] res;
      logic        err;
      logic        ovf;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        err;
      logic        ovf;
      int          lat;
      int          hold;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Independent reference: value view of A*2^n versus the truncated result.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int hold);
      exp_t e;
      int   n;
      e.hold = hold;
      if (b[31]) begin
         e.res = '0; e.err = 1'b1; e.ovf = 1'b0; e.lat = 1;
      end else begin
         n     = (b > 32) ? 32 : int'(b);
         e.res = (n == 32) ? 32'h0 : (a << n);
         e.err = 1'b0;
         e.ovf = ((longint'($signed(a)) <<< n) != longint'($signed(e.res)));
         e.lat = (n == 0) ? 1 : n + 1;
      end
      return e;
   endfunction

   task automatic drive_accept(input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (!o_in_ready && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_in_ready) chk("in_ready_timeout", 64'(o_in_ready), 64'd1);
      i_valid = 1'b1;
      i_arg_A = a;
      i_arg_B = b;
      @(posedge i_clk);
      #1 i_valid = 1'b0;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input exp_t e);
      drive_accept(a, b);
      sb.push_back(e);
   endtask

   task automatic collect();
      exp_t e;
      int   lat, low;
      logic [31:0] held_res;
      logic        held_ovf;
      @(negedge i_clk);
      lat = 1;
      low = o_in_ready ? 0 : 1;
      while (!o_valid && lat < 100) begin
         @(negedge i_clk);
         lat++;
         if (!o_in_ready) low++;
      end
      if (sb.size() == 0) begin
         chk("sb_empty", 64'd1, 64'd0);
         return;
      end
      e = sb.pop_front();
      chk("latency", 64'(lat), 64'(e.lat));
      chk("in_ready_low_cycles", 64'(low), 64'(e.lat));
      chk("result", 64'(o_result), 64'(e.res));
      chk("error", 64'(o_error), 64'(e.err));
      chk("overflow", 64'(o_overflow), 64'(e.ovf));
      held_res = o_result;
      held_ovf = o_overflow;
      if (e.hold > 0) begin
         i_ready = 1'b0;
         for (int k = 0; k < e.hold; k++) begin
            i_valid = k[0];
            i_arg_A = $urandom;
            i_arg_B = 32'd1;
            @(negedge i_clk);
            chk("hold_valid", 64'(o_valid), 64'd1);
            chk("hold_result", 64'(o_result), 64'(held_res));
            chk("hold_overflow", 64'(o_overflow), 64'(held_ovf));
            chk("hold_in_ready", 64'(o_in_ready), 64'd0);
         end
         i_valid = 1'b0;
         i_ready = 1'b1;
      end
      @(negedge i_clk);
      chk("post_valid", 64'(o_valid), 64'd0);
      chk("post_in_ready", 64'(o_in_ready), 64'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, 64'(o_valid), 64'd0);
      chk({tag, "_result"}, 64'(o_result), 64'd0);
      chk({tag, "_error"}, 64'(o_error), 64'd0);
      chk({tag, "_overflow"}, 64'(o_overflow), 64'd0);
      chk({tag, "_busy"}, 64'(o_busy), 64'd0);
      chk({tag, "_in_ready"}, 64'(o_in_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl[11];
      exp_t e;
      int   seen;
      logic [31:0] ra, rb;

      tbl[0]  = '{32'h0000_0003, 32'd4,          0, 32'h0000_0030, 1'b0, 1'b0, 5};
      tbl[1]  = '{32'h1234_5678, 32'd0,          0, 32'h1234_5678, 1'b0, 1'b0, 1};
      tbl[2]  = '{32'h0000_0005, 32'hFFFF_FFFF,  0, 32'h0,         1'b1, 1'b0, 1};
      tbl[3]  = '{32'h4000_0000, 32'd1,          0, 32'h8000_0000, 1'b0, 1'b1, 2};
      tbl[4]  = '{32'hFFFF_FFFF, 32'd31,         0, 32'h8000_0000, 1'b0, 1'b0, 32};
      tbl[5]  = '{32'hFFFF_FFFF, 32'd32,         0, 32'h0,         1'b0, 1'b1, 33};
      tbl[6]  = '{32'h0000_0001, 32'd1000,       0, 32'h0,         1'b0, 1'b1, 33};
      tbl[7]  = '{32'h0000_0000, 32'h7FFF_FFFF,  0, 32'h0,         1'b0, 1'b0, 33};
      tbl[8]  = '{32'h0000_0001, 32'd2,         10, 32'h4,         1'b0, 1'b0, 3};
      tbl[9]  = '{32'h7FFF_FFFF, 32'd1,          0, 32'hFFFF_FFFE, 1'b0, 1'b1, 2};
      tbl[10] = '{32'hDEAD_BEEF, 32'h8000_0000,  0, 32'h0,         1'b1, 1'b0, 1};

      // Reset state
      #3;
      chk_reset_vals("reset");
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // Directed table
      for (int i = 0; i < 11; i++) begin
         e = '{tbl[i].res, tbl[i].err, tbl[i].ovf, tbl[i].lat, tbl[i].hold};
         send(tbl[i].a, tbl[i].b, e);
         collect();
      end

      // Random vectors against the reference model
      for (int i = 0; i < 10; i++) begin
         ra = $urandom;
         rb = (i % 4 == 3) ? (32'h8000_0000 | $urandom) : 32'($urandom_range(0, 40));
         send(ra, rb, model(ra, rb, (i % 3 == 0) ? 2 : 0));
         collect();
      end

      // Clear on the 3rd SHIFT cycle: no result ever appears
      drive_accept(32'd1, 32'd20);
      repeat (3) @(negedge i_clk);
      i_clear = 1'b1;
      @(posedge i_clk);
      #1 i_clear = 1'b0;
      @(negedge i_clk);
      chk("clear_busy", 64'(o_busy), 64'd0);
      chk("clear_in_ready", 64'(o_in_ready), 64'd1);
      seen = 0;
      repeat (25) begin
         @(negedge i_clk);
         if (o_valid) seen++;
      end
      chk("clear_no_valid", 64'(seen), 64'd0);

      // valid and clear together in IDLE: discarded
      i_valid = 1'b1; i_clear = 1'b1;
      i_arg_A = 32'd7; i_arg_B = 32'd0;
      @(posedge i_clk);
      #1 begin i_valid = 1'b0; i_clear = 1'b0; end
      @(negedge i_clk);
      chk("clear_accept_busy", 64'(o_busy), 64'd0);
      chk("clear_accept_valid", 64'(o_valid), 64'd0);

      // Async reset mid-SHIFT: outputs drop before any clock edge
      drive_accept(32'd3, 32'd20);
      repeat (3) @(negedge i_clk);
      chk("pre_reset_busy", 64'(o_busy), 64'd1);
      #2 i_rst_n = 1'b0;
      #1 chk_reset_vals("async_reset");
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // Recovery after reset
      send(32'h0000_00F0, 32'd8, model(32'h0000_00F0, 32'd8, 0));
      collect();
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
